// File: rtl/exe_stage.sv
// Execute stage: Val2 shifter, ALU with NZCV flags, branch target adder and
// the EXE/MEM pipeline register plus the status register.
module exe_stage (
  input  logic        CLK,
  input  logic        RST,
  input  logic        MEM_Stall,
  input  logic        WB_EN_In,
  input  logic        MEM_R_EN_In,
  input  logic        MEM_W_EN_In,
  input  logic        B_In,
  input  logic        S_In,
  input  logic        imm_In,
  input  logic [3:0]  EXE_CMD_In,
  input  logic [31:0] PC_In,
  input  logic [31:0] Val_Rn_In,
  input  logic [31:0] Val_Rm_In,
  input  logic [11:0] Shift_operand_In,
  input  logic [23:0] Signed_imm_24_In,
  input  logic [3:0]  Dest_In,
  output logic [31:0] Br_Addr,
  output logic        Br_Taken,
  output logic        WB_EN_Out,
  output logic        MEM_R_EN_Out,
  output logic        MEM_W_EN_Out,
  output logic [31:0] ALU_Res_Out,
  output logic [31:0] Val_Rm_Out,
  output logic [3:0]  Dest_Out,
  output logic [3:0]  SR_Out
);

  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_MVN = 4'b1001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;

  logic        wb_en_q, wb_en_d;
  logic        mem_r_en_q, mem_r_en_d;
  logic        mem_w_en_q, mem_w_en_d;
  logic [31:0] alu_res_q, alu_res_d;
  logic [31:0] val_rm_q, val_rm_d;
  logic [3:0]  dest_q, dest_d;
  logic [3:0]  sr_q, sr_d;

  logic [31:0] val2;
  logic [31:0] imm32;
  logic [4:0]  rot_amt;
  logic [4:0]  sh_amt;
  logic [63:0] rot_imm64;
  logic [63:0] rot_rm64;

  // Rotations use a doubled word so an amount of 0 falls out naturally.
  always_comb begin
    imm32     = {24'b0, Shift_operand_In[7:0]};
    rot_amt   = {Shift_operand_In[11:8], 1'b0};
    sh_amt    = Shift_operand_In[11:7];
    rot_imm64 = {imm32, imm32} >> rot_amt;
    rot_rm64  = {Val_Rm_In, Val_Rm_In} >> sh_amt;
    val2      = 32'b0;
    if (imm_In) begin
      val2 = rot_imm64[31:0];
    end else if (MEM_R_EN_In || MEM_W_EN_In) begin
      val2 = {20'b0, Shift_operand_In};
    end else begin
      case (Shift_operand_In[6:5])
        2'b00:   val2 = Val_Rm_In << sh_amt;
        2'b01:   val2 = Val_Rm_In >> sh_amt;
        2'b10:   val2 = $signed(Val_Rm_In) >>> sh_amt;
        default: val2 = rot_rm64[31:0];
      endcase
    end
  end

  logic [32:0] arith;
  logic [31:0] res;
  logic        c_new, v_new;

  always_comb begin
    arith = 33'b0;
    res   = 32'b0;
    c_new = sr_q[1];
    v_new = sr_q[0];
    case (EXE_CMD_In)
      CMD_MOV: res = val2;
      CMD_MVN: res = ~val2;
      CMD_ADD, CMD_ADC: begin
        arith = {1'b0, Val_Rn_In} + {1'b0, val2};
        if (EXE_CMD_In == CMD_ADC) arith = arith + {32'b0, sr_q[1]};
        res   = arith[31:0];
        c_new = arith[32];
        v_new = (Val_Rn_In[31] == val2[31]) && (res[31] != Val_Rn_In[31]);
      end
      CMD_SUB, CMD_SBC: begin
        arith = {1'b0, Val_Rn_In} - {1'b0, val2};
        if (EXE_CMD_In == CMD_SBC) arith = arith - {32'b0, ~sr_q[1]};
        res   = arith[31:0];
        c_new = ~arith[32];
        v_new = (Val_Rn_In[31] != val2[31]) && (res[31] != Val_Rn_In[31]);
      end
      CMD_AND: res = Val_Rn_In & val2;
      CMD_ORR: res = Val_Rn_In | val2;
      CMD_EOR: res = Val_Rn_In ^ val2;
      default: res = 32'b0;
    endcase
  end

  assign Br_Addr  = PC_In + {{6{Signed_imm_24_In[23]}}, Signed_imm_24_In, 2'b00};
  assign Br_Taken = B_In;

  always_comb begin
    wb_en_d    = wb_en_q;
    mem_r_en_d = mem_r_en_q;
    mem_w_en_d = mem_w_en_q;
    alu_res_d  = alu_res_q;
    val_rm_d   = val_rm_q;
    dest_d     = dest_q;
    sr_d       = sr_q;
    if (!MEM_Stall) begin
      wb_en_d    = WB_EN_In;
      mem_r_en_d = MEM_R_EN_In;
      mem_w_en_d = MEM_W_EN_In;
      alu_res_d  = res;
      val_rm_d   = Val_Rm_In;
      dest_d     = Dest_In;
      if (S_In && !B_In) sr_d = {res[31], (res == 32'b0), c_new, v_new};
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wb_en_q    <= 1'b0;
      mem_r_en_q <= 1'b0;
      mem_w_en_q <= 1'b0;
      alu_res_q  <= 32'b0;
      val_rm_q   <= 32'b0;
      dest_q     <= 4'b0;
      sr_q       <= 4'b0;
    end else begin
      wb_en_q    <= wb_en_d;
      mem_r_en_q <= mem_r_en_d;
      mem_w_en_q <= mem_w_en_d;
      alu_res_q  <= alu_res_d;
      val_rm_q   <= val_rm_d;
      dest_q     <= dest_d;
      sr_q       <= sr_d;
    end
  end

  assign WB_EN_Out    = wb_en_q;
  assign MEM_R_EN_Out = mem_r_en_q;
  assign MEM_W_EN_Out = mem_w_en_q;
  assign ALU_Res_Out  = alu_res_q;
  assign Val_Rm_Out   = val_rm_q;
  assign Dest_Out     = dest_q;
  assign SR_Out       = sr_q;

endmodule

// File: tb/tb_exe_stage.sv
// Directed bench for exe_stage: hand-computed ALU, shifter, flag, branch,
// stall and reset expectations.
module tb_exe_stage;

  logic        CLK = 1'b0;
  logic        RST;
  logic        MEM_Stall;
  logic        WB_EN_In, MEM_R_EN_In, MEM_W_EN_In, B_In, S_In, imm_In;
  logic [3:0]  EXE_CMD_In;
  logic [31:0] PC_In, Val_Rn_In, Val_Rm_In;
  logic [11:0] Shift_operand_In;
  logic [23:0] Signed_imm_24_In;
  logic [3:0]  Dest_In;
  logic [31:0] Br_Addr;
  logic        Br_Taken;
  logic        WB_EN_Out, MEM_R_EN_Out, MEM_W_EN_Out;
  logic [31:0] ALU_Res_Out, Val_Rm_Out;
  logic [3:0]  Dest_Out, SR_Out;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  exe_stage dut (
    .CLK(CLK), .RST(RST), .MEM_Stall(MEM_Stall),
    .WB_EN_In(WB_EN_In), .MEM_R_EN_In(MEM_R_EN_In), .MEM_W_EN_In(MEM_W_EN_In),
    .B_In(B_In), .S_In(S_In), .imm_In(imm_In), .EXE_CMD_In(EXE_CMD_In),
    .PC_In(PC_In), .Val_Rn_In(Val_Rn_In), .Val_Rm_In(Val_Rm_In),
    .Shift_operand_In(Shift_operand_In), .Signed_imm_24_In(Signed_imm_24_In),
    .Dest_In(Dest_In), .Br_Addr(Br_Addr), .Br_Taken(Br_Taken),
    .WB_EN_Out(WB_EN_Out), .MEM_R_EN_Out(MEM_R_EN_Out), .MEM_W_EN_Out(MEM_W_EN_Out),
    .ALU_Res_Out(ALU_Res_Out), .Val_Rm_Out(Val_Rm_Out), .Dest_Out(Dest_Out),
    .SR_Out(SR_Out)
  );

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    RST = 0; MEM_Stall = 0;
    WB_EN_In = 0; MEM_R_EN_In = 0; MEM_W_EN_In = 0; B_In = 0; S_In = 0; imm_In = 0;
    EXE_CMD_In = 4'b0; PC_In = 0; Val_Rn_In = 0; Val_Rm_In = 0;
    Shift_operand_In = 12'h0; Signed_imm_24_In = 24'h0; Dest_In = 4'h0;
  endtask

  // Issue one op with a 12-bit operand; imm selects immediate rotate form.
  task automatic issue(input logic [3:0] cmd, input logic s, input logic imm,
                       input logic [31:0] rn, input logic [31:0] rm,
                       input logic [11:0] so);
    EXE_CMD_In = cmd; S_In = s; imm_In = imm;
    Val_Rn_In = rn; Val_Rm_In = rm; Shift_operand_In = so;
  endtask

  task automatic test_reset();
    clear_inputs();
    RST = 1; MEM_Stall = 1; WB_EN_In = 1; MEM_R_EN_In = 1; MEM_W_EN_In = 1; S_In = 1;
    EXE_CMD_In = 4'b1001; Val_Rm_In = 32'hDEADBEEF; Dest_In = 4'hF;
    step();
    step();
    checks++; if (ALU_Res_Out !== 32'h0) begin errors++; $display("FAIL reset_alu got %h exp 0", ALU_Res_Out); end
    checks++; if (SR_Out !== 4'h0) begin errors++; $display("FAIL reset_sr got %b exp 0000", SR_Out); end
    checks++; if ({WB_EN_Out, MEM_R_EN_Out, MEM_W_EN_Out} !== 3'b000) begin errors++; $display("FAIL reset_en got %b exp 000", {WB_EN_Out, MEM_R_EN_Out, MEM_W_EN_Out}); end
    checks++; if (Val_Rm_Out !== 32'h0 || Dest_Out !== 4'h0) begin errors++; $display("FAIL reset_data got %h/%h exp 0/0", Val_Rm_Out, Dest_Out); end
    clear_inputs();
  endtask

  task automatic test_add_flags();
    clear_inputs();
    WB_EN_In = 1; Dest_In = 4'h3;
    issue(4'b0010, 1, 1, 32'h7FFFFFFF, 32'h00001234, 12'h001);
    #1;
    checks++; if (Br_Taken !== 1'b0) begin errors++; $display("FAIL add_brtaken got %b exp 0", Br_Taken); end
    step();
    checks++; if (ALU_Res_Out !== 32'h80000000) begin errors++; $display("FAIL add_res got %h exp 80000000", ALU_Res_Out); end
    checks++; if (SR_Out !== 4'b1001) begin errors++; $display("FAIL add_sr got %b exp 1001", SR_Out); end
    checks++; if (WB_EN_Out !== 1'b1 || Dest_Out !== 4'h3 || Val_Rm_Out !== 32'h00001234) begin errors++; $display("FAIL add_pipe got %b/%h/%h exp 1/3/00001234", WB_EN_Out, Dest_Out, Val_Rm_Out); end
  endtask

  task automatic test_cmp();
    clear_inputs();
    issue(4'b0100, 1, 1, 32'd5, 32'h0, 12'h005);
    step();
    checks++; if (SR_Out !== 4'b0110) begin errors++; $display("FAIL cmp_sr got %b exp 0110", SR_Out); end
    checks++; if (WB_EN_Out !== 1'b0) begin errors++; $display("FAIL cmp_wb got %b exp 0", WB_EN_Out); end
    checks++; if (ALU_Res_Out !== 32'h0) begin errors++; $display("FAIL cmp_res got %h exp 0", ALU_Res_Out); end
  endtask

  task automatic test_shifter();
    logic [3:0]  cmd [9];
    logic        im  [9];
    logic [31:0] rn  [9];
    logic [31:0] rm  [9];
    logic [11:0] so  [9];
    logic [31:0] exp [9];
    clear_inputs();
    cmd[0]=4'b0001; im[0]=1; rn[0]=0;            rm[0]=0;            so[0]=12'h4FF; exp[0]=32'hFF000000;
    cmd[1]=4'b0001; im[1]=0; rn[1]=0;            rm[1]=32'h80000000; so[1]=12'h240; exp[1]=32'hF8000000;
    cmd[2]=4'b0001; im[2]=0; rn[2]=0;            rm[2]=32'h000000F1; so[2]=12'h200; exp[2]=32'h00000F10;
    cmd[3]=4'b0001; im[3]=0; rn[3]=0;            rm[3]=32'h80000010; so[3]=12'h220; exp[3]=32'h08000001;
    cmd[4]=4'b0001; im[4]=0; rn[4]=0;            rm[4]=32'h000000F1; so[4]=12'h260; exp[4]=32'h1000000F;
    cmd[5]=4'b0001; im[5]=0; rn[5]=0;            rm[5]=32'h80000000; so[5]=12'h040; exp[5]=32'h80000000;
    cmd[6]=4'b1001; im[6]=1; rn[6]=0;            rm[6]=0;            so[6]=12'h000; exp[6]=32'hFFFFFFFF;
    cmd[7]=4'b1000; im[7]=1; rn[7]=32'h000000FF; rm[7]=0;            so[7]=12'h00F; exp[7]=32'h000000F0;
    cmd[8]=4'b0000; im[8]=1; rn[8]=32'h12345678; rm[8]=0;            so[8]=12'h0FF; exp[8]=32'h00000000;
    for (int i = 0; i < 9; i++) begin
      issue(cmd[i], 0, im[i], rn[i], rm[i], so[i]);
      step();
      checks++; if (ALU_Res_Out !== exp[i]) begin errors++; $display("FAIL shift_vec%0d got %h exp %h", i, ALU_Res_Out, exp[i]); end
    end
    checks++; if (SR_Out !== 4'b0110) begin errors++; $display("FAIL shift_sr_hold got %b exp 0110", SR_Out); end
    MEM_R_EN_In = 1;
    issue(4'b0010, 0, 0, 32'h00001000, 32'h0, 12'hFFF);
    step();
    checks++; if (ALU_Res_Out !== 32'h00001FFF || MEM_R_EN_Out !== 1'b1) begin errors++; $display("FAIL ldr_addr got %h/%b exp 00001FFF/1", ALU_Res_Out, MEM_R_EN_Out); end
  endtask

  task automatic test_branch();
    clear_inputs();
    B_In = 1; WB_EN_In = 1; PC_In = 32'h100; Signed_imm_24_In = 24'hFFFFFE;
    issue(4'b0010, 1, 1, 32'h7FFFFFFF, 32'h0, 12'h001);
    #1;
    checks++; if (Br_Addr !== 32'h000000F8) begin errors++; $display("FAIL br_addr_neg got %h exp 000000F8", Br_Addr); end
    checks++; if (Br_Taken !== 1'b1) begin errors++; $display("FAIL br_taken got %b exp 1", Br_Taken); end
    step();
    checks++; if (SR_Out !== 4'b0110) begin errors++; $display("FAIL br_sr_hold got %b exp 0110", SR_Out); end
    checks++; if (WB_EN_Out !== 1'b1) begin errors++; $display("FAIL br_no_flush got %b exp 1", WB_EN_Out); end
    PC_In = 32'h1000; Signed_imm_24_In = 24'h000010;
    #1;
    checks++; if (Br_Addr !== 32'h00001040) begin errors++; $display("FAIL br_addr_pos got %h exp 00001040", Br_Addr); end
    clear_inputs();
  endtask

  task automatic test_adc_sbc();
    clear_inputs();
    issue(4'b0100, 1, 1, 32'd5, 32'h0, 12'h005);
    step();
    issue(4'b0011, 0, 1, 32'd1, 32'h0, 12'h001);
    step();
    checks++; if (ALU_Res_Out !== 32'd3) begin errors++; $display("FAIL adc_res got %h exp 3", ALU_Res_Out); end
    issue(4'b0111, 1, 1, 32'h80000000, 32'h0, 12'h001);
    step();
    checks++; if (ALU_Res_Out !== 32'h80000001 || SR_Out !== 4'b1010) begin errors++; $display("FAIL orr_flags got %h/%b exp 80000001/1010", ALU_Res_Out, SR_Out); end
    issue(4'b0100, 1, 1, 32'd1, 32'h0, 12'h002);
    step();
    checks++; if (ALU_Res_Out !== 32'hFFFFFFFF || SR_Out !== 4'b1000) begin errors++; $display("FAIL sub_borrow got %h/%b exp FFFFFFFF/1000", ALU_Res_Out, SR_Out); end
    issue(4'b0101, 0, 1, 32'd5, 32'h0, 12'h002);
    step();
    checks++; if (ALU_Res_Out !== 32'd2) begin errors++; $display("FAIL sbc_res got %h exp 2", ALU_Res_Out); end
  endtask

  task automatic test_stall_reset();
    clear_inputs();
    WB_EN_In = 1; MEM_W_EN_In = 1; Dest_In = 4'h7;
    issue(4'b0100, 1, 1, 32'd1, 32'h0000AAAA, 12'h002);
    step();
    checks++; if (ALU_Res_Out !== 32'hFFFFFFFF || SR_Out !== 4'b1000) begin errors++; $display("FAIL pre_stall got %h/%b exp FFFFFFFF/1000", ALU_Res_Out, SR_Out); end
    MEM_Stall = 1;
    for (int i = 0; i < 3; i++) begin
      WB_EN_In = 0; MEM_W_EN_In = 0; Dest_In = 4'(i + 1);
      issue(4'b0100, 1, 1, 32'd5, 32'(i + 100), 12'h005);
      step();
      checks++;
      if (ALU_Res_Out !== 32'hFFFFFFFF || SR_Out !== 4'b1000 || Dest_Out !== 4'h7 ||
          Val_Rm_Out !== 32'h0000AAAA || WB_EN_Out !== 1'b1 || MEM_W_EN_Out !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold%0d got %h/%b/%h/%h/%b%b exp FFFFFFFF/1000/7/0000AAAA/11",
                 i, ALU_Res_Out, SR_Out, Dest_Out, Val_Rm_Out, WB_EN_Out, MEM_W_EN_Out);
      end
    end
    RST = 1;
    step();
    checks++;
    if (ALU_Res_Out !== 32'h0 || SR_Out !== 4'h0 || Dest_Out !== 4'h0 || Val_Rm_Out !== 32'h0 ||
        {WB_EN_Out, MEM_R_EN_Out, MEM_W_EN_Out} !== 3'b000) begin
      errors++;
      $display("FAIL stall_reset got %h/%b/%h/%h exp all zero", ALU_Res_Out, SR_Out, Dest_Out, Val_Rm_Out);
    end
    RST = 0; MEM_Stall = 0;
    WB_EN_In = 1; Dest_In = 4'h9;
    issue(4'b0001, 0, 1, 32'h0, 32'h00000055, 12'h055);
    step();
    checks++; if (ALU_Res_Out !== 32'h55 || Dest_Out !== 4'h9 || WB_EN_Out !== 1'b1 || SR_Out !== 4'h0) begin errors++; $display("FAIL post_reset_load got %h/%h/%b/%b exp 55/9/1/0000", ALU_Res_Out, Dest_Out, WB_EN_Out, SR_Out); end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_add_flags();
    test_cmp();
    test_shifter();
    test_branch();
    test_adc_sbc();
    test_stall_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
